rf_read_arbiter: RTL and testbench

Round-robin arbiter that shares the register file's single 64-bit, 32-entry read port among several requesters. Each requester presents a 5-bit register number with a valid/ready handshake. The arbiter drives the read-port select with the granted address and returns the registered read data one cycle later, tagged to the winner. Register 31 always reads as zero.

---
 rtl/rf_read_arbiter.sv | 116 +++++++++++
 tb/tb_rf_read_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_read_arbiter.sv
// ---------------------------------------------------------------------------
// rf_read_arbiter
//
// Round-robin arbiter sharing one register-file read port among NREQ
// requesters. The winner's address drives the read-port select in the same
// cycle. The read data is captured and returned one cycle later, tagged with
// a one-hot response valid. The all-ones register (r31) always reads as zero.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous reset, active low
//   hold_i       suppresses any grant this cycle
//   req_valid_i  per-requester request valid
//   req_addr_i   per-requester register number, requester i at [i]
//   req_ready_o  one-hot grant (combinational)
//   rf_sel_o     read-port select; idles at the zero register
//   rf_data_i    read-port data, combinational from rf_sel_o
//   rsp_valid_o  one-hot registered response valid
//   rsp_data_o   registered read data
// ---------------------------------------------------------------------------
module rf_read_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 64,
    parameter int AW   = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    hold_i,
    input  logic [NREQ-1:0]         req_valid_i,
    input  logic [NREQ-1:0][AW-1:0] req_addr_i,
    output logic [NREQ-1:0]         req_ready_o,
    output logic [AW-1:0]           rf_sel_o,
    input  logic [DW-1:0]           rf_data_i,
    output logic [NREQ-1:0]         rsp_valid_o,
    output logic [DW-1:0]           rsp_data_o
);

    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW1 = PW + 1;
    localparam logic [AW-1:0] ZERO_REG = '1;

    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]   rspValid_q, rspValid_d;
    logic [DW-1:0]     rspData_q, rspData_d;

    logic [2*NREQ-1:0] dblValid;
    logic [NREQ-1:0]   rotValid;
    logic [PW1-1:0]    offset;
    logic [PW1-1:0]    winSum;
    logic [PW-1:0]     winIdx;
    logic              found;
    logic              grantActive;

    // Rotate the valid vector so the pointer's requester sits at bit 0, take
    // the first set bit, then map that offset back to a requester index.
    // The doubled vector makes the rotation a plain shift.
    always_comb begin
        dblValid = {req_valid_i, req_valid_i} >> ptr_q;
        rotValid = dblValid[NREQ-1:0];
        found    = 1'b0;
        offset   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rotValid[k]) begin
                found  = 1'b1;
                offset = PW1'(k);
            end
        end
        winSum = {1'b0, ptr_q} + offset;
        if (winSum >= PW1'(NREQ)) begin
            winSum = winSum - PW1'(NREQ);
        end
        winIdx      = winSum[PW-1:0];
        // Reset is folded in so no grant is advertised while in reset.
        grantActive = found && !hold_i && rst_ni;
    end

    // Grant and read-port select. With no grant the select parks on the
    // zero register, which has no side effects on the register file.
    always_comb begin
        req_ready_o = '0;
        rf_sel_o    = ZERO_REG;
        if (grantActive) begin
            req_ready_o[winIdx] = 1'b1;
            rf_sel_o            = req_addr_i[winIdx];
        end
    end

    // Next state: advance the pointer past the winner and load the response.
    // Response data holds its value when nothing is granted.
    always_comb begin
        ptr_d      = ptr_q;
        rspValid_d = '0;
        rspData_d  = rspData_q;
        if (grantActive) begin
            ptr_d      = (winIdx == PW'(NREQ - 1)) ? '0 : winIdx + 1'b1;
            rspValid_d = req_ready_o;
            rspData_d  = (rf_sel_o == ZERO_REG) ? '0 : rf_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            rspValid_q <= '0;
            rspData_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rspValid_q <= rspValid_d;
            rspData_q  <= rspData_d;
        end
    end

    assign rsp_valid_o = rspValid_q;
    assign rsp_data_o  = rspData_q;

endmodule

// File: tb/tb_rf_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_read_arbiter
//
// Self-checking bench for rf_read_arbiter (NREQ=4, DW=64, AW=5). A register
// file array behind the read port supplies rf_data. A reference model keeps
// the priority pointer as an integer and finds the winner by scanning
// requesters ptr, ptr+1, ... modulo NREQ.
// ---------------------------------------------------------------------------
module tb_rf_read_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 64;
    localparam int AW   = 5;

    typedef struct {
        logic            hold;
        logic [3:0]      valid;
        logic [3:0][4:0] addr;
        logic [3:0]      expReady;
        logic [4:0]      expSel;
        logic [3:0]      expRsp;
    } vec_t;

    logic                    clk;
    logic                    rstN;
    logic                    hold;
    logic [NREQ-1:0]         reqValid;
    logic [NREQ-1:0][AW-1:0] reqAddr;
    logic [NREQ-1:0]         reqReady;
    logic [AW-1:0]           rfSel;
    logic [DW-1:0]           rfData;
    logic [NREQ-1:0]         rspValid;
    logic [DW-1:0]           rspData;

    logic [DW-1:0]           regfile [32];

    int                      testsRun = 0;
    int                      failures = 0;

    int                      mPtr;
    logic [3:0]              mRspValid;
    logic [63:0]             mRspData;

    logic [3:0]              obsReady;
    logic [4:0]              obsSel;
    logic [3:0]              obsRsp;

    vec_t                    vecs [16];
    logic [3:0]              pending;
    logic [3:0][4:0]         rAddr;
    int                      waitCnt [4];
    logic                    hRand;

    rf_read_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .hold_i      (hold),
        .req_valid_i (reqValid),
        .req_addr_i  (reqAddr),
        .req_ready_o (reqReady),
        .rf_sel_o    (rfSel),
        .rf_data_i   (rfData),
        .rsp_valid_o (rspValid),
        .rsp_data_o  (rspData)
    );

    // The read-port mux bank, modelled as a plain array lookup.
    assign rfData = regfile[rfSel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, check the combinational
    // grant against the model, cross the rising edge, then check the
    // registered response. Returns on the next falling edge.
    task automatic applyStimulus(input logic h, input logic [3:0] v, input logic [3:0][4:0] a);
        int win;
        int idx;
        logic [3:0] expReady;
        logic [4:0] expSel;
        hold     = h;
        reqValid = v;
        reqAddr  = a;
        #1;
        win = -1;
        if (!h) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (mPtr + k) % NREQ;
                if (win < 0 && v[idx]) win = idx;
            end
        end
        expReady = '0;
        expSel   = 5'd31;
        if (win >= 0) begin
            expReady[win] = 1'b1;
            expSel        = a[win];
        end
        obsReady = reqReady;
        obsSel   = rfSel;
        checkOutput("req_ready", 64'(reqReady), 64'(expReady));
        checkOutput("rf_sel", 64'(rfSel), 64'(expSel));
        @(posedge clk);
        #1;
        if (win >= 0) begin
            mPtr      = (win + 1) % NREQ;
            mRspValid = 4'(1 << win);
            mRspData  = (a[win] == 5'd31) ? 64'd0 : regfile[a[win]];
        end else begin
            mRspValid = '0;
        end
        obsRsp = rspValid;
        checkOutput("rsp_valid", 64'(rspValid), 64'(mRspValid));
        checkOutput("rsp_data", rspData, mRspData);
        @(negedge clk);
    endtask

    initial begin
        rstN     = 1'b1;
        hold     = 1'b0;
        reqValid = '0;
        reqAddr  = '0;
        for (int i = 0; i < 32; i++) begin
            regfile[i] = 64'(i) * 64'h0001_0001_0001_0001 + 64'h1234_0000_0000_0000;
        end
        regfile[5]  = 64'h0123_4567_89AB_CDEF;
        regfile[31] = 64'hFFFF_FFFF_FFFF_FFFF;

        // Reset entry: outputs must be quiet even with every requester valid.
        #1 rstN  = 1'b0;
        reqValid = 4'b1111;
        #2;
        checkOutput("reset_rsp_valid", 64'(rspValid), 64'd0);
        checkOutput("reset_rsp_data", rspData, 64'd0);
        checkOutput("reset_req_ready", 64'(reqReady), 64'd0);
        checkOutput("reset_rf_sel", 64'(rfSel), 64'd31);
        @(negedge clk);
        @(negedge clk);
        reqValid  = '0;
        rstN      = 1'b1;
        mPtr      = 0;
        mRspValid = '0;
        mRspData  = '0;

        // Directed table: single request, fairness, zero register,
        // pointer skip, idle and hold.
        vecs[0]  = '{1'b0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd5},   4'b0001, 5'd5,  4'b0001};
        vecs[1]  = '{1'b0, 4'b1000, {5'd9, 5'd0, 5'd0, 5'd0},   4'b1000, 5'd9,  4'b1000};
        vecs[2]  = '{1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},   4'b0001, 5'd1,  4'b0001};
        vecs[3]  = '{1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},   4'b0010, 5'd2,  4'b0010};
        vecs[4]  = '{1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},   4'b0100, 5'd3,  4'b0100};
        vecs[5]  = '{1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},   4'b1000, 5'd4,  4'b1000};
        vecs[6]  = '{1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},   4'b0001, 5'd1,  4'b0001};
        vecs[7]  = '{1'b0, 4'b0010, {5'd0, 5'd0, 5'd31, 5'd0},  4'b0010, 5'd31, 4'b0010};
        vecs[8]  = '{1'b0, 4'b1001, {5'd7, 5'd0, 5'd0, 5'd6},   4'b1000, 5'd7,  4'b1000};
        vecs[9]  = '{1'b0, 4'b1001, {5'd7, 5'd0, 5'd0, 5'd6},   4'b0001, 5'd6,  4'b0001};
        vecs[10] = '{1'b0, 4'b1001, {5'd7, 5'd0, 5'd0, 5'd6},   4'b1000, 5'd7,  4'b1000};
        vecs[11] = '{1'b0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},   4'b0000, 5'd31, 4'b0000};
        vecs[12] = '{1'b1, 4'b0100, {5'd0, 5'd12, 5'd0, 5'd0},  4'b0000, 5'd31, 4'b0000};
        vecs[13] = '{1'b1, 4'b0100, {5'd0, 5'd12, 5'd0, 5'd0},  4'b0000, 5'd31, 4'b0000};
        vecs[14] = '{1'b1, 4'b0100, {5'd0, 5'd12, 5'd0, 5'd0},  4'b0000, 5'd31, 4'b0000};
        vecs[15] = '{1'b0, 4'b0100, {5'd0, 5'd12, 5'd0, 5'd0},  4'b0100, 5'd12, 4'b0100};

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].hold, vecs[i].valid, vecs[i].addr);
            checkOutput($sformatf("vec%0d_ready", i), 64'(obsReady), 64'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d_sel", i), 64'(obsSel), 64'(vecs[i].expSel));
            checkOutput($sformatf("vec%0d_rsp", i), 64'(obsRsp), 64'(vecs[i].expRsp));
        end
        checkOutput("zero_reg_forced", 64'(regfile[31] == 64'hFFFF_FFFF_FFFF_FFFF), 64'd1);

        // Mid-operation reset: grant requester 3, then reset while its
        // response is still being presented.
        applyStimulus(1'b0, 4'b1000, {5'd20, 5'd0, 5'd0, 5'd0});
        checkOutput("midreset_grant", 64'(obsRsp), 64'b1000);
        reqValid = 4'b1111;
        reqAddr  = {5'd4, 5'd3, 5'd2, 5'd1};
        rstN     = 1'b0;
        #1;
        checkOutput("midreset_rsp_valid", 64'(rspValid), 64'd0);
        checkOutput("midreset_rsp_data", rspData, 64'd0);
        checkOutput("midreset_req_ready", 64'(reqReady), 64'd0);
        checkOutput("midreset_rf_sel", 64'(rfSel), 64'd31);
        @(negedge clk);
        rstN      = 1'b1;
        mPtr      = 0;
        mRspValid = '0;
        mRspData  = '0;
        applyStimulus(1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1});
        checkOutput("postreset_first", 64'(obsReady), 64'b0001);

        // Randomized traffic: requests stay up until granted, hold pulses
        // occasionally and register contents change between cycles.
        pending = '0;
        rAddr   = '0;
        for (int i = 0; i < 4; i++) waitCnt[i] = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                regfile[$urandom_range(0, 30)] = {$urandom, $urandom};
            end
            for (int i = 0; i < 4; i++) begin
                if (!pending[i] && $urandom_range(0, 1) == 1) begin
                    pending[i] = 1'b1;
                    rAddr[i]   = 5'($urandom_range(0, 31));
                    waitCnt[i] = 0;
                end
            end
            hRand = ($urandom_range(0, 7) == 0);
            applyStimulus(hRand, pending, rAddr);
            if (obsReady != 4'b0000) begin
                for (int i = 0; i < 4; i++) begin
                    if (obsReady[i]) begin
                        checkOutput("starvation_bound", 64'(waitCnt[i] <= NREQ - 1), 64'd1);
                    end else if (pending[i]) begin
                        waitCnt[i]++;
                    end
                end
            end
            pending = pending & ~obsReady;
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
